// File: rtl/boost_pwm_pkg.sv
// Shared types and constants for the boost converter PWM gate generator.
package boost_pwm_pkg;

    localparam int unsigned CNT_W_DEF  = 12;
    localparam int unsigned PERIOD_RST = 2500;
    localparam int unsigned MIN_PERIOD = 2;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SOFTSTART,
        ST_RUN,
        ST_FAULT
    } pwm_state_t;

    // Gate may only switch in the two states that run the period counter.
    function automatic logic is_active(input pwm_state_t s);
        return (s == ST_SOFTSTART) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/boost_pwm_ctrl_sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/boost_pwm_ctrl.sv
// Boost converter PWM gate generator: period counter, shadowed duty with
// soft-start ramp, and an overvoltage shutdown FSM. All outputs registered.
module boost_pwm_ctrl
    import boost_pwm_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned DUTY_MAX = 2250,
    parameter int unsigned SS_STEP  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty_cmd,
    input  logic             duty_load,
    input  logic             ov_fault,
    output logic             gate,
    output logic             cycle_start,
    output logic [CNT_W-1:0] duty_active,
    output logic             fault
);

    localparam logic [CNT_W-1:0] DUTY_MAX_C = CNT_W'(DUTY_MAX);
    localparam logic [CNT_W-1:0] MIN_P_C    = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] P_RST_C    = CNT_W'(PERIOD_RST);
    localparam logic [CNT_W:0]   SS_STEP_C  = (CNT_W+1)'(SS_STEP);

    pwm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             gate_q, gate_d;
    logic             cs_q, cs_d;
    logic             fault_q, fault_d;

    logic             ov_sync;
    logic             boundary;
    logic [CNT_W-1:0] per_in;
    logic [CNT_W-1:0] target;
    logic [CNT_W:0]   ss_sum;

    sync2 u_ov_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ov_fault),
        .q     (ov_sync)
    );

    // Shadow is bypassed so a load on the boundary cycle feeds that boundary's target.
    always_comb begin
        per_in   = (period < MIN_P_C) ? MIN_P_C : period;
        shadow_d = duty_load ? duty_cmd : shadow_q;
        target   = shadow_d;
        if (target > DUTY_MAX_C) begin
            target = DUTY_MAX_C;
        end
        if (target > per_in - 1'b1) begin
            target = per_in - 1'b1;
        end
        ss_sum   = {1'b0, duty_q} + SS_STEP_C;
        boundary = is_active(state_q) && (cnt_q == per_q - 1'b1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        duty_d  = duty_q;

        if (ov_sync) begin
            state_d = ST_FAULT;
        end else if (!en) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_SOFTSTART;
        end else if (boundary) begin
            per_d = per_in;
            cnt_d = '0;
            // Reaching or overshooting the target ends the ramp.
            if ((state_q == ST_RUN) || (ss_sum >= {1'b0, target})) begin
                duty_d  = target;
                state_d = ST_RUN;
            end else begin
                duty_d = ss_sum[CNT_W-1:0];
            end
        end else if (is_active(state_q)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (!is_active(state_d)) begin
            cnt_d  = '0;
            duty_d = '0;
        end

        gate_d  = is_active(state_d) && (cnt_d < duty_d);
        cs_d    = is_active(state_d) && (cnt_d == '0);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            per_q    <= P_RST_C;
            shadow_q <= '0;
            duty_q   <= '0;
            gate_q   <= 1'b0;
            cs_q     <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            shadow_q <= shadow_d;
            duty_q   <= duty_d;
            gate_q   <= gate_d;
            cs_q     <= cs_d;
            fault_q  <= fault_d;
        end
    end

    assign gate        = gate_q;
    assign cycle_start = cs_q;
    assign duty_active = duty_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_boost_pwm_ctrl.sv
// Self-checking bench for boost_pwm_ctrl: directed vectors and sequences plus
// randomized stimulus against a cycle-level reference model.
`timescale 1ns/1ps
module tb_boost_pwm_ctrl;
    import boost_pwm_pkg::*;

    localparam int DMAX = 2250;
    localparam int STEP = 5;

    localparam int M_IDLE  = 0;
    localparam int M_SS    = 1;
    localparam int M_RUN   = 2;
    localparam int M_FAULT = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    cnt_t period;
    cnt_t duty_cmd;
    logic duty_load;
    logic ov_fault;
    logic gate;
    logic cycle_start;
    cnt_t duty_active;
    logic fault;

    always #5 clk = ~clk;

    boost_pwm_ctrl #(
        .CNT_W    (CNT_W_DEF),
        .DUTY_MAX (DMAX),
        .SS_STEP  (STEP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .period      (period),
        .duty_cmd    (duty_cmd),
        .duty_load   (duty_load),
        .ov_fault    (ov_fault),
        .gate        (gate),
        .cycle_start (cycle_start),
        .duty_active (duty_active),
        .fault       (fault)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int m_mode, m_pos, m_len, m_duty, m_shadow;
    int ovq[$];

    typedef struct {
        cnt_t per;
        cnt_t cmd;
        int   exp_duty;
        int   exp_len;
    } vec_t;
    vec_t vecs[8];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_pos    = 0;
        m_len    = 2500;
        m_duty   = 0;
        m_shadow = 0;
        ovq.delete();
        ovq.push_back(0);
        ovq.push_back(0);
    endtask

    // One clock edge of the specified behaviour, using the inputs held across it.
    task automatic model_step();
        int sync_ov;
        int tgt;
        ovq.push_front(int'(ov_fault));
        sync_ov = ovq[2];
        void'(ovq.pop_back());
        if (duty_load) m_shadow = int'(duty_cmd);
        if (sync_ov != 0) begin
            m_mode = M_FAULT;
        end else if (!en) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_SS;
            m_pos  = 0;
        end else if (m_mode != M_FAULT) begin
            if (m_pos == m_len - 1) begin
                m_len = (int'(period) < 2) ? 2 : int'(period);
                tgt   = imin(imin(m_shadow, DMAX), m_len - 1);
                if (m_mode == M_RUN || m_duty + STEP >= tgt) begin
                    m_duty = tgt;
                    m_mode = M_RUN;
                end else begin
                    m_duty = m_duty + STEP;
                end
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        if (m_mode == M_IDLE || m_mode == M_FAULT) begin
            m_pos  = 0;
            m_duty = 0;
        end
    endtask

    task automatic compare_model();
        logic act_m, eg, ec, ef;
        act_m = (m_mode == M_SS) || (m_mode == M_RUN);
        eg = act_m && (m_pos < m_duty);
        ec = act_m && (m_pos == 0);
        ef = (m_mode == M_FAULT);
        checks++;
        if (gate !== eg || cycle_start !== ec || int'(duty_active) != m_duty || fault !== ef) begin
            errors++;
            $display("FAIL model: gate=%0b cs=%0b duty=%0d fault=%0b, expected gate=%0b cs=%0b duty=%0d fault=%0b (cycle %0d)",
                     gate, cycle_start, duty_active, fault, eg, ec, m_duty, ef, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic wait_cs(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!cycle_start && n < budget);
        if (!cycle_start) check("cs_timeout", 0, 1);
    endtask

    // Called on a cycle_start cycle; returns on the next one.
    task automatic measure(input int change_at, input cnt_t new_period, output int len, output int hi);
        len = 0;
        hi  = 0;
        do begin
            len++;
            hi += int'(gate);
            if (len == change_at) period = new_period;
            tick();
        end while (!cycle_start && len < 5000);
    endtask

    task automatic load(input cnt_t v);
        duty_cmd  = v;
        duty_load = 1'b1;
        tick();
        duty_load = 1'b0;
    endtask

    initial begin
        int len, hi;

        vecs[0] = '{12'd2500, 12'd3000, 2250, 2500};
        vecs[1] = '{12'd1000, 12'd1250,  999, 1000};
        vecs[2] = '{12'd200,  12'd0,       0,  200};
        vecs[3] = '{12'd1,    12'd1,       1,    2};
        vecs[4] = '{12'd0,    12'd7,       1,    2};
        vecs[5] = '{12'd50,   12'd49,     49,   50};
        vecs[6] = '{12'd300,  12'd120,   120,  300};
        vecs[7] = '{12'd2500, 12'd1250, 1250, 2500};

        rst_n = 1'b0; en = 1'b0; period = 12'd2500; duty_cmd = '0;
        duty_load = 1'b0; ov_fault = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_gate", int'(gate), 0);
        check("rst_cs", int'(cycle_start), 0);
        check("rst_duty", int'(duty_active), 0);
        check("rst_fault", int'(fault), 0);
        rst_n = 1'b1;

        // Soft-start: first period uses the reset period, then ramps by STEP.
        en = 1'b1; period = 12'd200; duty_cmd = 12'd100; duty_load = 1'b1;
        tick();
        duty_load = 1'b0;
        check("en_to_cs", int'(cycle_start), 1);
        check("ss_start_duty", int'(duty_active), 0);
        for (int k = 1; k <= 20; k++) begin
            wait_cs(3000);
            check($sformatf("ss_duty_%0d", k), int'(duty_active), STEP * k);
        end
        measure(-1, '0, len, hi);
        check("ss_final_len", len, 200);
        check("ss_final_high", hi, 100);

        for (int i = 0; i < 8; i++) begin
            period = vecs[i].per;
            load(vecs[i].cmd);
            wait_cs(5000);
            check($sformatf("vec%0d_duty", i), int'(duty_active), vecs[i].exp_duty);
            measure(-1, '0, len, hi);
            check($sformatf("vec%0d_len", i), len, vecs[i].exp_len);
            check($sformatf("vec%0d_high", i), hi, vecs[i].exp_duty);
        end

        // Overvoltage at cnt=100 in RUN with duty 1250.
        repeat (100) tick();
        check("gate_before_ov", int'(gate), 1);
        ov_fault = 1'b1;
        tick();
        check("ov_edge1_fault", int'(fault), 0);
        check("ov_edge1_gate", int'(gate), 1);
        tick();
        check("ov_edge2_fault", int'(fault), 0);
        check("ov_edge2_gate", int'(gate), 1);
        tick();
        check("ov_edge3_fault", int'(fault), 1);
        check("ov_edge3_gate", int'(gate), 0);
        ov_fault = 1'b0;
        repeat (10) tick();
        check("fault_hold_en", int'(fault), 1);
        en = 1'b0;
        tick();
        check("fault_clear", int'(fault), 0);
        check("idle_duty", int'(duty_active), 0);
        en = 1'b1;
        tick();
        check("restart_cs", int'(cycle_start), 1);
        check("restart_duty0", int'(duty_active), 0);
        wait_cs(3000);
        check("restart_step", int'(duty_active), STEP);

        load(12'd5);
        wait_cs(3000);
        check("ss_to_run_duty", int'(duty_active), 5);
        load(12'd1250);
        wait_cs(3000);
        check("run_step_up", int'(duty_active), 1250);

        // Period change mid-period: old period completes first.
        measure(300, 12'd1000, len, hi);
        check("old_period_len", len, 2500);
        check("old_period_high", hi, 1250);
        check("new_period_duty", int'(duty_active), 999);
        measure(-1, '0, len, hi);
        check("new_period_len", len, 1000);
        check("new_period_high", hi, 999);

        // duty_load on the boundary cycle.
        repeat (999) tick();
        check("pre_boundary_cs", int'(cycle_start), 0);
        load(12'd400);
        check("boundary_load_cs", int'(cycle_start), 1);
        check("boundary_load_duty", int'(duty_active), 400);
        measure(-1, '0, len, hi);
        check("boundary_load_len", len, 1000);
        check("boundary_load_high", hi, 400);

        // Asynchronous reset with gate high.
        load(12'd900);
        wait_cs(2000);
        check("pre_rst_duty", int'(duty_active), 900);
        repeat (500) tick();
        check("gate_pre_rst", int'(gate), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_gate", int'(gate), 0);
        check("async_rst_cs", int'(cycle_start), 0);
        check("async_rst_duty", int'(duty_active), 0);
        check("async_rst_fault", int'(fault), 0);
        model_reset();
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_gate", int'(gate), 0);
        check("post_rst_duty", int'(duty_active), 0);
        en = 1'b1;
        tick();
        check("post_rst_idle_start", int'(cycle_start), 1);

        for (int i = 0; i < 6000; i++) begin
            en        = ($urandom_range(0, 149) != 0);
            period    = cnt_t'($urandom_range(0, 40));
            duty_load = ($urandom_range(0, 7) == 0);
            duty_cmd  = ($urandom_range(0, 9) == 0) ? cnt_t'($urandom()) : cnt_t'($urandom_range(0, 45));
            if (ov_fault) ov_fault = ($urandom_range(0, 3) != 0);
            else          ov_fault = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/boost_pwm_ctrl.md
# boost_pwm_ctrl

Digital PWM gate-drive generator for the boost converter power stage. It replaces the ideal rectangular source on the switch control node: it produces the relay/MOSFET gate signal at a programmable period and duty, with soft-start and an overvoltage shutdown. It sits directly upstream of the switch and receives duty commands from the regulation loop and a fault flag from the output-voltage comparator.

## Interface
- CNT_W, 12: width of the period counter and the duty registers.
- DUTY_MAX, 2250: absolute duty ceiling in clock counts (90 % of 2500).
- SS_STEP, 5: soft-start duty increment per PWM period, in counts.
- clk  in  1  system clock (100 MHz nominal; 2500 counts gives 40 kHz).
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  converter enable; low forces IDLE and clears FAULT.
- period  in  CNT_W  PWM period in counts; sampled at period boundaries.
- duty_cmd  in  CNT_W  requested on-time in counts.
- duty_load  in  1  one-cycle strobe; captures duty_cmd into the shadow register.
- ov_fault  in  1  asynchronous overvoltage flag from the comparator.
- gate  out  1  switch drive; high means the switch is closed.
- cycle_start  out  1  one-cycle pulse on the first clock of each PWM period.
- duty_active  out  CNT_W  duty currently applied.
- fault  out  1  high while in FAULT.

## Operation
- States:
  - IDLE: counter held at 0, gate 0, duty_active 0.
  - SOFTSTART: duty_active ramps toward the target.
  - RUN: duty_active equals the target.
  - FAULT: gate 0, counter held at 0.
- Transitions:
  - IDLE to SOFTSTART when en=1.
  - SOFTSTART to RUN on the boundary where duty_active reaches the target.
  - Any state to FAULT when the synchronized ov_fault is 1. FAULT has priority over en.
  - FAULT to IDLE only when en=0 and the synchronized ov_fault is 0.
  - SOFTSTART or RUN to IDLE when en=0.
- Period counter counts 0 to P-1, then wraps. P is the latched period, clamped to a minimum of 2.
- Boundary = the cycle where cnt==P-1. The following values update only at a boundary:
  - P takes the new period input.
  - target = min(shadow, DUTY_MAX, P_new-1).
- SOFTSTART: at each boundary, duty_active = min(duty_active+SS_STEP, target).
- RUN: at each boundary, duty_active = target, so duty steps in either direction are immediate.
- If the target drops below duty_active during SOFTSTART, duty_active = target and the state moves to RUN.
- gate_next = (cnt_next < duty_active_next) in SOFTSTART and RUN, and 0 otherwise.
  - duty_active 0 gives gate permanently low.
  - duty_active ≥ P is impossible because of the clamp.
- duty_load and a boundary in the same cycle: the new shadow value is used for that boundary's target update.
- ov_fault passes through a 2-flop synchronizer. No other input is synchronized; all other inputs are synchronous to clk.

## Timing
- Reset values: gate 0, cycle_start 0, duty_active 0, fault 0, state IDLE, cnt 0, shadow 0, P = 2500.
- All outputs are registered.
- en rising to first cycle_start: 1 cycle. cycle_start and the counter at 0 appear in the same cycle.
- duty_load to effect: at the next boundary. gate reflects the new duty from the following period's first cycle.
- ov_fault assertion to gate low: at most 3 clk edges (2 synchronizer edges plus 1 register edge). fault rises in the same cycle that gate falls.
- Reset asserted mid-period: all outputs go to reset values immediately. No partial pulse completes.

## Structure
- Package boost_pwm_pkg holds:
  - the state enum (IDLE, SOFTSTART, RUN, FAULT);
  - CNT_W-based types;
  - default constants PERIOD_RST=2500 and MIN_PERIOD=2.
- One sub-module: sync2, the 2-flop synchronizer for ov_fault, with asynchronous active-low reset to 0.
- Counter, duty logic and FSM stay in the top module.

## Test plan
- Reset, then en=1, period=2500, duty_cmd=1250 loaded, SS_STEP=5:
  - duty_active goes 5, 10, … and reaches 1250 after 250 periods;
  - state is then RUN;
  - gate high for exactly 1250 of 2500 clocks per period.
- In RUN, load duty_cmd=3000 with period=2500:
  - duty_active clamps to 2250;
  - gate high for 2250 clocks.
- In RUN at duty 1250, pulse ov_fault at cnt=100:
  - gate low within 3 clocks and fault=1;
  - after ov_fault drops with en still 1, the block stays in FAULT;
  - en=0 gives IDLE; en=1 restarts soft-start from 0.
- Change period to 1000 mid-period with duty 1250:
  - the old period completes;
  - the next period is 1000 clocks with duty_active=999;
  - gate stays high for 999 of 1000 clocks.
- Pulse duty_load with duty_cmd=400 on the boundary cycle:
  - the very next period uses duty 400.
- Assert rst_n low at cnt=500 with gate high:
  - gate is 0 asynchronously;
  - after release, all outputs are at reset values and the state is IDLE.
